// File: rtl/laser_sched_pkg.sv
// ============================================================================
//  Module      : laser_sched_pkg
//  Description : Shared constants, state encoding and timer helper for the
//                laser fire scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package laser_sched_pkg;

    localparam int NUM_LASER = 8;
    localparam int CHNL_W    = $clog2(NUM_LASER);

    // One-hot encoding shared with laser_control
    localparam logic [7:0] ST_IDLE      = 8'b0000_0001;
    localparam logic [7:0] ST_WAIT_TICK = 8'b0000_0010;
    localparam logic [7:0] ST_WAIT_RDY  = 8'b0000_0100;
    localparam logic [7:0] ST_FIRE      = 8'b0000_1000;
    localparam logic [7:0] ST_WAIT_DONE = 8'b0001_0000;
    localparam logic [7:0] ST_HOLDOFF   = 8'b0010_0000;

    typedef enum logic [7:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_TICK = ST_WAIT_TICK,
        S_WAIT_RDY  = ST_WAIT_RDY,
        S_FIRE      = ST_FIRE,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_HOLDOFF   = ST_HOLDOFF
    } state_t;

    // True on the last cycle of a lim-cycle window; widened so lim=0 cannot wrap
    function automatic logic tmr_hit(input logic [15:0] cnt, input logic [15:0] lim);
        return ({1'b0, cnt} + 17'd1) >= {1'b0, lim};
    endfunction

endpackage

`default_nettype wire

// File: rtl/laser_fire_sched_if.sv
// ============================================================================
//  Module      : laser_fire_sched_if
//  Description : Encoder/TDC side inputs and laser_control side outputs of
//                the laser fire scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface laser_fire_sched_if;

    logic        i_scan_en;
    logic        i_angle_tick;
    logic [7:0]  i_chnl_mask;
    logic        i_fixed_mode;
    logic [2:0]  i_fixed_chnl;
    logic        i_tdc_ready;
    logic        i_tdc_done;
    logic        o_angle_sync;
    logic        o_laser_switch;
    logic [7:0]  o_laser_setnum;
    logic        o_busy;
    logic        o_timeout;
    logic [15:0] o_fire_cnt;
    logic [15:0] o_miss_cnt;

    modport master (
        output i_scan_en, i_angle_tick, i_chnl_mask, i_fixed_mode, i_fixed_chnl,
               i_tdc_ready, i_tdc_done,
        input  o_angle_sync, o_laser_switch, o_laser_setnum, o_busy, o_timeout,
               o_fire_cnt, o_miss_cnt
    );

    modport slave (
        input  i_scan_en, i_angle_tick, i_chnl_mask, i_fixed_mode, i_fixed_chnl,
               i_tdc_ready, i_tdc_done,
        output o_angle_sync, o_laser_switch, o_laser_setnum, o_busy, o_timeout,
               o_fire_cnt, o_miss_cnt
    );

endinterface

`default_nettype wire

// File: rtl/rr_chnl_pick.sv
// ============================================================================
//  Module      : rr_chnl_pick
//  Description : Combinational round-robin channel picker: first set mask bit
//                strictly after i_last, searching upward modulo NUM_LASER.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_chnl_pick
    import laser_sched_pkg::*;
(
    input  wire logic [NUM_LASER-1:0] i_mask,
    input  wire logic [CHNL_W-1:0]    i_last,
    output logic      [CHNL_W-1:0]    o_next,
    output logic                      o_valid
);

    logic [CHNL_W-1:0] w_idx;
    logic              w_found;

    // Offset NUM_LASER wraps onto i_last itself, so a lone set bit repeats
    always_comb begin
        o_next  = i_last;
        o_valid = |i_mask;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_LASER; i++) begin
            w_idx = i_last + CHNL_W'(i);
            if (!w_found && i_mask[w_idx]) begin
                o_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/laser_fire_sched.sv
// ============================================================================
//  Module      : laser_fire_sched
//  Description : Turns encoder angle ticks into gated single-cycle fire
//                requests for laser_control. Optional SCHED_STATS_EN adds
//                fire/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module laser_fire_sched
    import laser_sched_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC  = 16'd2000,
    parameter logic [7:0]  MIN_GAP_CYC  = 8'd20,
    parameter logic [15:0] RDY_WAIT_CYC = 16'd500
) (
    input  wire logic         i_clk_100m,
    input  wire logic         i_rst_n,
    laser_fire_sched_if.slave bus
);

    state_t            state_q, state_d;
    logic [15:0]       tmr_q, tmr_d;
    logic [7:0]        setnum_q, setnum_d;
    logic [CHNL_W-1:0] last_q, last_d;
    logic              timeout_q, timeout_d;
    logic              switch_q;

    logic [CHNL_W-1:0] w_rr_next;
    logic              w_rr_valid;
    logic              w_sched_ok;
    logic              w_rdy_expired;
    logic              w_fire_evt;
    logic              w_miss_evt;

    rr_chnl_pick u_rr_chnl_pick (
        .i_mask  (bus.i_chnl_mask),
        .i_last  (last_q),
        .o_next  (w_rr_next),
        .o_valid (w_rr_valid)
    );

    assign w_sched_ok = bus.i_scan_en & (bus.i_fixed_mode | w_rr_valid);

    always_comb begin
        state_d       = state_q;
        setnum_d      = setnum_q;
        last_d        = last_q;
        timeout_d     = 1'b0;
        w_rdy_expired = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_sched_ok) state_d = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (!w_sched_ok) begin
                    state_d = S_IDLE;
                end else if (bus.i_angle_tick) begin
                    state_d = S_WAIT_RDY;
                    if (bus.i_fixed_mode) begin
                        setnum_d = 8'(bus.i_fixed_chnl);
                    end else begin
                        setnum_d = 8'(w_rr_next);
                        last_d   = w_rr_next;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (bus.i_tdc_ready) begin
                    state_d = S_FIRE;
                end else if (tmr_hit(tmr_q, RDY_WAIT_CYC)) begin
                    state_d       = S_WAIT_TICK;
                    timeout_d     = 1'b1;
                    w_rdy_expired = 1'b1;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.i_tdc_done) begin
                    state_d = S_HOLDOFF;
                end else if (tmr_hit(tmr_q, TIMEOUT_CYC)) begin
                    state_d   = S_HOLDOFF;
                    timeout_d = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (tmr_hit(tmr_q, 16'(MIN_GAP_CYC)))
                    state_d = bus.i_scan_en ? S_WAIT_TICK : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Done timeout is measured from the fire cycle, so FIRE->WAIT_DONE keeps counting
        tmr_d = ((state_d != state_q) && (state_d != S_WAIT_DONE)) ? 16'd0 : tmr_q + 16'd1;

        w_fire_evt = (state_q == S_FIRE);
        w_miss_evt = (bus.i_angle_tick && (state_q != S_WAIT_TICK)) || w_rdy_expired;
    end

    always_ff @(posedge i_clk_100m) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= 16'd0;
            setnum_q  <= 8'd0;
            last_q    <= CHNL_W'(NUM_LASER - 1);
            timeout_q <= 1'b0;
            switch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            setnum_q  <= setnum_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
            switch_q  <= 1'b1;
        end
    end

    assign bus.o_angle_sync   = (state_q == S_FIRE);
    assign bus.o_laser_switch = switch_q;
    assign bus.o_laser_setnum = setnum_q;
    assign bus.o_busy         = (state_q != S_IDLE) && (state_q != S_WAIT_TICK);
    assign bus.o_timeout      = timeout_q;

`ifdef SCHED_STATS_EN
    logic [15:0] fire_cnt_q, fire_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Fire count wraps, miss count saturates
    always_comb begin
        fire_cnt_d = fire_cnt_q + {15'd0, w_fire_evt};
        miss_cnt_d = miss_cnt_q;
        if (w_miss_evt && (miss_cnt_q != 16'hFFFF))
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk_100m) begin
        if (!i_rst_n) begin
            fire_cnt_q <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            fire_cnt_q <= fire_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.o_fire_cnt = fire_cnt_q;
    assign bus.o_miss_cnt = miss_cnt_q;
`else
    logic unused_stats_evt;
    assign unused_stats_evt = w_fire_evt | w_miss_evt;

    assign bus.o_fire_cnt = 16'd0;
    assign bus.o_miss_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_laser_fire_sched.sv
// ============================================================================
//  Module      : tb_laser_fire_sched
//  Description : Directed bench for laser_fire_sched: round-robin/fixed shot
//                table plus hand-written timeout, busy-tick and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_laser_fire_sched;

    typedef struct {
        logic [7:0] mask;
        logic       fixed;
        logic [2:0] fchnl;
        logic [7:0] exp_set;
    } shot_vec_t;

    localparam int NVEC = 20;

    logic      clk = 1'b0;
    logic      rst_n;
    shot_vec_t vecs [NVEC];
    int        n_chk = 0;
    int        n_err = 0;
    int        exp_fire = 0;
    int        exp_miss = 0;
    int        syncs;
    int        early;
    int        done_at;

    laser_fire_sched_if bus ();

    laser_fire_sched dut (
        .i_clk_100m (clk),
        .i_rst_n    (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sx(input int v);
`ifdef SCHED_STATS_EN
        return 16'(v);
`else
        return 16'd0 & 16'(v);
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sync"},   32'(bus.o_angle_sync),   0);
        chk({tag, "_switch"}, 32'(bus.o_laser_switch), 0);
        chk({tag, "_setnum"}, 32'(bus.o_laser_setnum), 0);
        chk({tag, "_busy"},   32'(bus.o_busy),         0);
        chk({tag, "_tmo"},    32'(bus.o_timeout),      0);
        chk({tag, "_fire"},   32'(bus.o_fire_cnt),     0);
        chk({tag, "_miss"},   32'(bus.o_miss_cnt),     0);
    endtask

    // One complete shot on a 100-cycle tick period, done 10 cycles after sync
    task automatic shot(input logic [7:0] exp_set, input string tag);
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        chk({tag, "_setnum"},     32'(bus.o_laser_setnum), 32'(exp_set));
        chk({tag, "_sync_early"}, 32'(bus.o_angle_sync),   0);
        step();
        chk({tag, "_sync_t2"},    32'(bus.o_angle_sync),   1);
        chk({tag, "_busy"},       32'(bus.o_busy),         1);
        exp_fire++;
        step();
        chk({tag, "_sync_once"},  32'(bus.o_angle_sync),   0);
        chk({tag, "_fire_cnt"},   32'(bus.o_fire_cnt),     32'(sx(exp_fire)));
        repeat (9) step();
        bus.i_tdc_done = 1'b1;
        step();
        bus.i_tdc_done = 1'b0;
        repeat (87) step();
        chk({tag, "_miss_cnt"},   32'(bus.o_miss_cnt),     32'(sx(exp_miss)));
    endtask

    initial begin
        for (int i = 0; i < 9; i++) vecs[i] = '{8'hFF, 1'b0, 3'd0, 8'(i % 8)};
        vecs[9]  = '{8'hA4, 1'b0, 3'd0, 8'd2};
        vecs[10] = '{8'hA4, 1'b0, 3'd0, 8'd5};
        vecs[11] = '{8'hA4, 1'b0, 3'd0, 8'd7};
        vecs[12] = '{8'hA4, 1'b0, 3'd0, 8'd2};
        vecs[13] = '{8'hA4, 1'b0, 3'd0, 8'd5};
        vecs[14] = '{8'h10, 1'b0, 3'd0, 8'd4};
        vecs[15] = '{8'h10, 1'b0, 3'd0, 8'd4};
        vecs[16] = '{8'h10, 1'b0, 3'd0, 8'd4};
        vecs[17] = '{8'h00, 1'b1, 3'd6, 8'd6};
        vecs[18] = '{8'h00, 1'b1, 3'd6, 8'd6};
        vecs[19] = '{8'hFF, 1'b0, 3'd0, 8'd5};

        rst_n            = 1'b0;
        bus.i_scan_en    = 1'b0;
        bus.i_angle_tick = 1'b0;
        bus.i_chnl_mask  = 8'h00;
        bus.i_fixed_mode = 1'b0;
        bus.i_fixed_chnl = 3'd0;
        bus.i_tdc_ready  = 1'b0;
        bus.i_tdc_done   = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");

        bus.i_scan_en   = 1'b1;
        bus.i_chnl_mask = 8'hFF;
        bus.i_tdc_ready = 1'b1;
        rst_n           = 1'b1;
        step();
        chk("switch_after_release", 32'(bus.o_laser_switch), 1);
        chk("busy_wait_tick",       32'(bus.o_busy),         0);

        // Round-robin and fixed-mode shot table
        for (int v = 0; v < NVEC; v++) begin
            bus.i_chnl_mask  = vecs[v].mask;
            bus.i_fixed_mode = vecs[v].fixed;
            bus.i_fixed_chnl = vecs[v].fchnl;
            shot(vecs[v].exp_set, $sformatf("vec%0d", v));
        end

        // Empty mask without fixed mode parks in IDLE; ticks there are misses
        bus.i_chnl_mask  = 8'h00;
        bus.i_fixed_mode = 1'b0;
        step();
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        exp_miss++;
        syncs = 0;
        repeat (4) begin
            step();
            if (bus.o_angle_sync) syncs++;
        end
        chk("idle_no_sync", 32'(syncs), 0);
        chk("idle_busy",    32'(bus.o_busy), 0);
        chk("idle_miss",    32'(bus.o_miss_cnt), 32'(sx(exp_miss)));
        bus.i_chnl_mask = 8'hFF;
        step();

        // Done timeout: pulse 2000 cycles after sync, then MIN_GAP holdoff
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        chk("tmo_setnum", 32'(bus.o_laser_setnum), 6);
        step();
        chk("tmo_sync", 32'(bus.o_angle_sync), 1);
        exp_fire++;
        early = 0;
        for (int i = 0; i < 1999; i++) begin
            step();
            if (bus.o_timeout) early++;
        end
        chk("tmo_early", 32'(early), 0);
        step();
        chk("tmo_pulse",    32'(bus.o_timeout),  1);
        chk("tmo_fire_cnt", 32'(bus.o_fire_cnt), 32'(sx(exp_fire)));
        step();
        chk("tmo_pulse_end", 32'(bus.o_timeout), 0);
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        exp_miss++;
        repeat (17) step();
        chk("holdoff_busy_last", 32'(bus.o_busy), 1);
        step();
        chk("holdoff_released", 32'(bus.o_busy), 0);
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        chk("post_tmo_setnum", 32'(bus.o_laser_setnum), 7);
        step();
        chk("post_tmo_sync", 32'(bus.o_angle_sync), 1);
        exp_fire++;
        step();
        repeat (9) step();
        bus.i_tdc_done = 1'b1;
        step();
        bus.i_tdc_done = 1'b0;
        repeat (25) step();
        chk("post_tmo_miss", 32'(bus.o_miss_cnt), 32'(sx(exp_miss)));

        // Ready timeout with a tick on the expiring cycle: one miss only
        bus.i_tdc_ready  = 1'b0;
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        chk("rdy_setnum", 32'(bus.o_laser_setnum), 0);
        repeat (499) step();
        chk("rdy_no_tmo_yet", 32'(bus.o_timeout), 0);
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        exp_miss++;
        chk("rdy_tmo_pulse", 32'(bus.o_timeout),  1);
        chk("rdy_tmo_miss",  32'(bus.o_miss_cnt), 32'(sx(exp_miss)));
        chk("rdy_tmo_idle",  32'(bus.o_busy),     0);
        chk("rdy_tmo_fire",  32'(bus.o_fire_cnt), 32'(sx(exp_fire)));
        bus.i_tdc_ready = 1'b1;
        step();
        chk("rdy_tmo_end", 32'(bus.o_timeout), 0);

        // Ticks every 5 cycles: one shot per 35 cycles, the rest are misses
        syncs   = 0;
        done_at = -1;
        for (int c = 0; c < 140; c++) begin
            bus.i_angle_tick = ((c % 5) == 0);
            bus.i_tdc_done   = (c == done_at);
            if (bus.o_angle_sync) begin
                syncs++;
                done_at = c + 10;
            end
            step();
        end
        bus.i_angle_tick = 1'b0;
        bus.i_tdc_done   = 1'b0;
        exp_fire += 4;
        exp_miss += 24;
        chk("burst_syncs", 32'(syncs), 4);
        chk("burst_fire",  32'(bus.o_fire_cnt), 32'(sx(exp_fire)));
        chk("burst_miss",  32'(bus.o_miss_cnt), 32'(sx(exp_miss)));
        chk("burst_last_setnum", 32'(bus.o_laser_setnum), 4);
        repeat (10) step();

        // Reset during WAIT_DONE
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        step();
        chk("pre_rst_sync", 32'(bus.o_angle_sync), 1);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk_all_zero("mid_rst");
        step();
        chk("mid_rst_no_sync", 32'(bus.o_angle_sync), 0);
        rst_n = 1'b1;
        step();
        chk("rst_release_switch", 32'(bus.o_laser_switch), 1);
        exp_fire = 0;
        exp_miss = 0;
        shot(8'd0, "post_rst");

        // Scan disable mid-shot finishes through holdoff into IDLE
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        step();
        chk("scan_off_sync", 32'(bus.o_angle_sync), 1);
        exp_fire++;
        step();
        bus.i_scan_en = 1'b0;
        repeat (5) step();
        bus.i_tdc_done = 1'b1;
        step();
        bus.i_tdc_done = 1'b0;
        repeat (19) step();
        chk("scan_off_holdoff", 32'(bus.o_busy), 1);
        step();
        chk("scan_off_idle", 32'(bus.o_busy), 0);
        bus.i_angle_tick = 1'b1;
        step();
        bus.i_angle_tick = 1'b0;
        exp_miss++;
        syncs = 0;
        repeat (4) begin
            step();
            if (bus.o_angle_sync) syncs++;
        end
        chk("scan_off_no_sync", 32'(syncs), 0);
        chk("scan_off_miss", 32'(bus.o_miss_cnt), 32'(sx(exp_miss)));
        chk("scan_off_fire", 32'(bus.o_fire_cnt), 32'(sx(exp_fire)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
